// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter_pkg
// Purpose: Bus request/response types, size encodings and arbiter enums
//          shared by mem_port_arbiter and mem_arb_pick.
// Ports  : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

  // Access size encodings (log2 of the byte count).
  localparam logic [2:0] MSIZE1 = 3'b000;
  localparam logic [2:0] MSIZE2 = 3'b001;
  localparam logic [2:0] MSIZE4 = 3'b010;
  localparam logic [2:0] MSIZE8 = 3'b011;

  // Width of the starvation counter; covers STARVE_LIMIT up to 15.
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // A fetch travels downstream as a 4-byte read with no write data.
  function automatic dbus_req_t ibus_to_dbus(input ibus_req_t r);
    dbus_req_t o;
    o        = '0;
    o.valid  = 1'b1;
    o.addr   = r.addr;
    o.size   = MSIZE4;
    o.strobe = 8'h00;
    o.data   = 64'h0;
    return o;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// ============================================================================
// Module : mem_arb_pick
// Purpose: Combinational winner selection between fetch and memory stage.
//          Build option MEM_ARB_RR_EN selects round-robin; otherwise fixed
//          dbus priority with an ibus starvation guard.
// Ports  : ireq_valid  - fetch request pending
//          dreq_valid  - memory-stage request pending
//          starve_cnt  - consecutive dbus grants while fetch waited
//          last_win    - owner of the most recent grant
//          grant_i     - fetch wins this cycle
//          grant_d     - memory stage wins this cycle
//          starve_en   - 1 when the starvation counter is meaningful
// Revision: 1.0 - initial release
// ============================================================================
module mem_arb_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    ireq_valid,
  input  logic                    dreq_valid,
  input  logic [STARVE_CNT_W-1:0] starve_cnt,
  input  arb_owner_t              last_win,
  output logic                    grant_i,
  output logic                    grant_d,
  output logic                    starve_en
);

`ifdef MEM_ARB_RR_EN
  // Counter and limit have no role in round-robin mode.
  logic unused_rr;
  assign unused_rr = ^{starve_cnt, 4'(STARVE_LIMIT)};

  always_comb begin
    // On contention the side that did not win last time goes next.
    grant_d   = dreq_valid && (!ireq_valid || (last_win == OWN_I));
    grant_i   = ireq_valid && !grant_d;
    starve_en = 1'b0;
  end
`else
  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic unused_fixed;
  assign unused_fixed = (last_win == OWN_D);

  always_comb begin
    // dbus wins unless fetch has already lost LIMIT times in a row.
    grant_d   = dreq_valid && !(ireq_valid && (starve_cnt == LIMIT));
    grant_i   = ireq_valid && !grant_d;
    starve_en = 1'b1;
  end
`endif

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : mem_port_arbiter
// Purpose: Shares one downstream dbus-protocol memory port between the
//          instruction fetch (ibus) and the memory stage (dbus). One
//          transaction outstanding; one IDLE bubble between transactions.
//          Build option MEM_ARB_RR_EN switches to round-robin arbitration.
// Ports  : clk, reset - clock, synchronous active-high reset
//          ireq/iresp - fetch request / response
//          dreq/dresp - memory-stage request / response
//          oreq/oresp - downstream request (registered) / response
// Revision: 1.0 - initial release
// ============================================================================
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  oreq,
  input  dbus_resp_t oresp
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  arb_state_t              state_q,      state_d;
  dbus_req_t               lreq_q,       lreq_d;
  logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  arb_owner_t              last_win_q,   last_win_d;

  logic grant_i;
  logic grant_d;
  logic starve_en;

  mem_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_pick (
    .ireq_valid (ireq.valid),
    .dreq_valid (dreq.valid),
    .starve_cnt (starve_cnt_q),
    .last_win   (last_win_q),
    .grant_i    (grant_i),
    .grant_d    (grant_d),
    .starve_en  (starve_en)
  );

  // Next-state, request latching and starvation bookkeeping.
  always_comb begin
    state_d      = state_q;
    lreq_d       = lreq_q;
    starve_cnt_d = starve_cnt_q;
    last_win_d   = last_win_q;

    case (state_q)
      ARB_IDLE: begin
        if (grant_d) begin
          state_d      = ARB_BUSY_D;
          lreq_d       = dreq;
          lreq_d.valid = 1'b1;
          last_win_d   = OWN_D;
          if (ireq.valid && (starve_cnt_q != LIMIT)) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
          end
        end else if (grant_i) begin
          state_d      = ARB_BUSY_I;
          lreq_d       = ibus_to_dbus(ireq);
          last_win_d   = OWN_I;
          starve_cnt_d = '0;
        end
        if (!ireq.valid || !starve_en) begin
          starve_cnt_d = '0;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        // The downstream access cannot be aborted; always wait for data_ok.
        if (oresp.data_ok) begin
          state_d = ARB_IDLE;
          lreq_d  = '0;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        lreq_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      lreq_q       <= '0;
      starve_cnt_q <= '0;
      last_win_q   <= OWN_I;
    end else begin
      state_q      <= state_d;
      lreq_q       <= lreq_d;
      starve_cnt_q <= starve_cnt_d;
      last_win_q   <= last_win_d;
    end
  end

  assign oreq = lreq_q;

  // A requester that dropped valid or moved its address (e.g. a flush) is
  // no longer the owner; its response is swallowed.
  logic i_owner_ok;
  logic d_owner_ok;

  assign i_owner_ok = (state_q == ARB_BUSY_I) && ireq.valid &&
                      (ireq.addr == lreq_q.addr);
  assign d_owner_ok = (state_q == ARB_BUSY_D) && dreq.valid &&
                      (dreq.addr == lreq_q.addr);

  always_comb begin
    iresp = '0;
    dresp = '0;
    if (i_owner_ok) begin
      iresp.addr_ok = oresp.addr_ok;
      iresp.data_ok = oresp.data_ok;
      if (oresp.data_ok) begin
        iresp.data = lreq_q.addr[2] ? oresp.data[63:32] : oresp.data[31:0];
      end
    end
    if (d_owner_ok) begin
      dresp.addr_ok = oresp.addr_ok;
      dresp.data_ok = oresp.data_ok;
      if (oresp.data_ok) begin
        dresp.data = oresp.data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_mem_port_arbiter
// Purpose: Self-checking bench for mem_port_arbiter. A downstream memory
//          model answers oreq; expected grants and response data are queued
//          as stimulus is driven and compared when the DUT produces them.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  oreq;
  dbus_resp_t oresp;

  mem_port_arbiter #(
    .STARVE_LIMIT (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .oreq  (oreq),
    .oresp (oresp)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 2;
  int i_rem    = 0;
  int d_rem    = 0;
  int last_rise_cyc = 0;
  int last_dok_cyc  = 0;
  int last_run      = 0;
  int run_len       = 0;
  logic prev_valid  = 1'b0;

  dbus_req_t   q_grant[$];
  logic [31:0] q_i[$];
  logic [63:0] q_d[$];

  task automatic check(input string tag, input logic [159:0] got,
                       input logic [159:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mem_data(input logic [63:0] a);
    if (a == 64'h8000_0004) return 64'hAAAA_BBBB_1111_2222;
    return {~a[31:0], a[31:0] ^ 32'h5A5A_5A5A};
  endfunction

  function automatic logic [31:0] exp_idata(input logic [63:0] a);
    logic [63:0] m;
    m = mem_data(a);
    return a[2] ? m[63:32] : m[31:0];
  endfunction

  function automatic dbus_req_t exp_igrant(input logic [63:0] a);
    dbus_req_t r;
    r       = '0;
    r.valid = 1'b1;
    r.addr  = a;
    r.size  = 3'b010;
    return r;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream memory: addr_ok on the first request cycle, data_ok after
  // lat further cycles.
  initial begin
    int cnt;
    cnt   = 0;
    oresp = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset || !oreq.valid) begin
        cnt   = 0;
        oresp = '0;
      end else begin
        oresp.addr_ok = (cnt == 0);
        if (cnt == lat) begin
          oresp.data_ok = 1'b1;
          oresp.data    = mem_data(oreq.addr);
          cnt = 0;
        end else begin
          oresp.data_ok = 1'b0;
          oresp.data    = '0;
          cnt++;
        end
      end
    end
  end

  // Monitor: grant order, responses, and the requesters' retirement.
  initial forever begin
    @(negedge clk);
    if (oreq.valid) run_len++;
    else if (prev_valid) begin
      last_run = run_len;
      run_len  = 0;
    end
    if (oreq.valid && !prev_valid) begin
      last_rise_cyc = cyc;
      if (q_grant.size() > 0) check("grant", oreq, q_grant.pop_front());
      else check("grant_unexpected", oreq, '0);
    end
    prev_valid = oreq.valid;
    if (iresp.data_ok) begin
      if (q_i.size() > 0) check("i_data", iresp.data, q_i.pop_front());
      else check("i_data_ok_unexpected", {iresp.data_ok, iresp.data}, '0);
      if (i_rem > 0) begin
        i_rem--;
        if (i_rem == 0) ireq.valid = 1'b0;
      end
    end
    if (dresp.data_ok) begin
      last_dok_cyc = cyc;
      if (q_d.size() > 0) check("d_data", dresp.data, q_d.pop_front());
      else check("d_data_ok_unexpected", {dresp.data_ok, dresp.data}, '0);
      if (d_rem > 0) begin
        d_rem--;
        if (d_rem == 0) dreq.valid = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_oreq(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (oreq.valid) break;
      tick();
    end
    check("wait_oreq_timeout", oreq.valid, 1);
  endtask

  task automatic wait_idle(input int budget);
    int stable;
    stable = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (i_rem == 0 && d_rem == 0 && !oreq.valid) stable++;
      else stable = 0;
      if (stable >= 3) break;
    end
    check("wait_idle_timeout", stable, 3);
    check("grant_q_drain", q_grant.size(), 0);
    check("i_q_drain", q_i.size(), 0);
    check("d_q_drain", q_d.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int drive_cyc;
    reset = 1'b1;
    ireq  = '0;
    dreq  = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    check("reset_oreq", oreq, '0);
    check("reset_iresp", iresp, '0);
    check("reset_dresp", dresp, '0);

    // Fetch only, upper word selected by addr[2].
    tick();
    lat        = 2;
    ireq.addr  = 64'h8000_0004;
    ireq.valid = 1'b1;
    i_rem      = 1;
    drive_cyc  = cyc;
    q_grant.push_back(exp_igrant(64'h8000_0004));
    q_i.push_back(32'hAAAA_BBBB);
    wait_idle(50);
    check("fetch_first_valid_cyc", last_rise_cyc, drive_cyc + 1);
    check("fetch_valid_len", last_run, 3);

    // Simultaneous store and fetch: D first, I after the bubble.
    lat         = 1;
    dreq.addr   = 64'h8000_0100;
    dreq.size   = MSIZE4;
    dreq.strobe = 8'h0F;
    dreq.data   = 64'h1234_5678_9ABC_DEF0;
    dreq.valid  = 1'b1;
    ireq.addr   = 64'h8000_0008;
    ireq.valid  = 1'b1;
    d_rem = 1;
    i_rem = 1;
    q_grant.push_back(dreq);
    q_grant.push_back(exp_igrant(64'h8000_0008));
    q_d.push_back(mem_data(64'h8000_0100));
    q_i.push_back(exp_idata(64'h8000_0008));
    wait_idle(50);
    check("simul_i_after_bubble", last_rise_cyc, last_dok_cyc + 2);

    // Dropped fetch, then re-raised with a new address in the data_ok cycle.
    lat        = 3;
    ireq.addr  = 64'h8000_0010;
    ireq.valid = 1'b1;
    i_rem      = 1;
    q_grant.push_back(exp_igrant(64'h8000_0010));
    wait_oreq(10);
    ireq.valid = 1'b0;
    i_rem      = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (oresp.data_ok) break;
    end
    check("drop_downstream_data_ok", oresp.data_ok, 1);
    ireq.addr  = 64'h8000_0040;
    ireq.valid = 1'b1;
    i_rem      = 1;
    q_grant.push_back(exp_igrant(64'h8000_0040));
    q_i.push_back(exp_idata(64'h8000_0040));
    #1;
    check("drop_no_iresp_data_ok", iresp.data_ok, 0);
    tick();
    check("drop_idle_after", oreq.valid, 0);
    wait_idle(50);

    // Reset during BUSY_D with both requesters pending; afterwards both stay
    // asserted so the grant pattern shows the arbiter restarted cleanly.
    lat         = 10;
    dreq.addr   = 64'h8000_0300;
    dreq.size   = MSIZE8;
    dreq.strobe = 8'h00;
    dreq.data   = 64'h0;
    dreq.valid  = 1'b1;
    ireq.addr   = 64'h8000_0024;
    ireq.valid  = 1'b1;
    d_rem = 100;
    i_rem = 100;
    q_grant.push_back(dreq);
    wait_oreq(10);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lat   = 1;
    #1;
    check("rst_mid_oreq", oreq, '0);
    check("rst_mid_dresp", dresp, '0);
    check("rst_mid_iresp", iresp, '0);
`ifdef MEM_ARB_RR_EN
    d_rem = 2;
    i_rem = 2;
    for (int k = 0; k < 2; k++) begin
      q_grant.push_back(dreq);
      q_grant.push_back(exp_igrant(64'h8000_0024));
    end
    repeat (2) q_d.push_back(mem_data(64'h8000_0300));
`else
    d_rem = 8;
    i_rem = 2;
    for (int k = 0; k < 2; k++) begin
      repeat (4) q_grant.push_back(dreq);
      q_grant.push_back(exp_igrant(64'h8000_0024));
    end
    repeat (8) q_d.push_back(mem_data(64'h8000_0300));
`endif
    repeat (2) q_i.push_back(exp_idata(64'h8000_0024));
    wait_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
